// File: rtl/fstore_pkg.sv
// rtl/fstore_pkg.sv - shared types and constants for the text-store TTY engine
package fstore_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLR,
        CLS
    } state_e;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    localparam int STRIDE_WORDS = 16;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_SP) && (c <= CH_TILDE);
    endfunction

endpackage

// File: rtl/fstore_tty_ctrl.sv
// rtl/fstore_tty_ctrl.sv - glass-TTY sequencer and host/engine arbiter for store port B
module fstore_tty_ctrl
    import fstore_pkg::*;
#(
    parameter int         COLS_VIS = 64,
    parameter int         ROWS     = 32,
    parameter logic [7:0] FILL     = 8'h20
) (
    input  logic        clk_data,
    input  logic        irst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        host_en,
    input  logic [7:0]  host_we,
    input  logic [10:0] host_addr,
    input  logic [63:0] host_din,
    output logic [63:0] host_dout,
    output logic        enb,
    output logic [7:0]  web,
    output logic [10:0] addrb,
    output logic [63:0] dinb,
    input  logic [63:0] doutb,
    output logic [5:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        busy
);

    localparam logic [6:0]  COL_LAST = 7'(COLS_VIS - 1);
    localparam logic [5:0]  ROW_MASK = 6'(ROWS - 1);
    localparam logic [10:0] CLS_LAST = 11'(ROWS * STRIDE_WORDS - 1);

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [5:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  char_q, char_d;

    logic        eng_en;
    logic [7:0]  eng_we;
    logic [10:0] eng_addr;
    logic [63:0] eng_din;
    logic        eng_ready;
    logic [5:0]  row_inc;

    assign row_inc = (row_q + 6'd1) & ROW_MASK;

    always_ff @(posedge clk_data) begin
        if (irst) begin
            state_q <= CLS;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            char_q  <= char_d;
        end
    end

    // A host cycle freezes the engine wherever it is; nothing below advances while host_en is high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        char_d    = char_q;
        eng_en    = 1'b0;
        eng_we    = '0;
        eng_addr  = '0;
        eng_din   = '0;
        eng_ready = 1'b0;

        case (state_q)
            IDLE: begin
                eng_ready = ~host_en;
                if (char_valid && !host_en) begin
                    char_d  = char_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!host_en) begin
                    state_d = IDLE;
                    if (is_printable(char_q)) begin
                        eng_en   = 1'b1;
                        eng_we   = 8'h01 << col_q[2:0];
                        eng_addr = {1'b0, row_q, col_q[6:3]};
                        eng_din  = {8{char_q}};
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            row_d   = row_inc;
                            cnt_d   = '0;
                            state_d = CLR;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else if (char_q == CH_CR) begin
                        col_d = '0;
                    end else if (char_q == CH_LF) begin
                        col_d   = '0;
                        row_d   = row_inc;
                        cnt_d   = '0;
                        state_d = CLR;
                    end else if (char_q == CH_BS) begin
                        if (col_q != 7'd0) begin
                            col_d = col_q - 7'd1;
                        end
                    end else if (char_q == CH_FF) begin
                        col_d   = '0;
                        row_d   = '0;
                        cnt_d   = '0;
                        state_d = CLS;
                    end
                end
            end
            CLR: begin
                if (!host_en) begin
                    eng_en   = 1'b1;
                    eng_we   = 8'hFF;
                    eng_addr = {1'b0, row_q, cnt_q[3:0]};
                    eng_din  = {8{FILL}};
                    if (cnt_q[3:0] == 4'hF) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            CLS: begin
                if (!host_en) begin
                    eng_en   = 1'b1;
                    eng_we   = 8'hFF;
                    eng_addr = cnt_q;
                    eng_din  = {8{FILL}};
                    if (cnt_q == CLS_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = CLS;
        endcase
    end

    // Reset forces port B quiet and reports busy, even before the state register has been reset.
    always_comb begin
        if (irst) begin
            enb        = 1'b0;
            web        = '0;
            addrb      = '0;
            dinb       = '0;
            char_ready = 1'b0;
            cur_row    = '0;
            cur_col    = '0;
            busy       = 1'b1;
        end else begin
            if (host_en) begin
                enb   = 1'b1;
                web   = host_we;
                addrb = host_addr;
                dinb  = host_din;
            end else begin
                enb   = eng_en;
                web   = eng_we;
                addrb = eng_addr;
                dinb  = eng_din;
            end
            char_ready = eng_ready;
            cur_row    = row_q;
            cur_col    = col_q;
            busy       = (state_q != IDLE);
        end
    end

    assign host_dout = doutb;

endmodule

// File: tb/tb_fstore_tty_ctrl.sv
// tb/tb_fstore_tty_ctrl.sv - directed self-checking bench for fstore_tty_ctrl
module tb_fstore_tty_ctrl;

    logic        clk_data = 1'b0;
    logic        irst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        host_en = 1'b0;
    logic [7:0]  host_we = 8'h00;
    logic [10:0] host_addr = 11'h000;
    logic [63:0] host_din = 64'h0;
    logic [63:0] host_dout;
    logic        enb;
    logic [7:0]  web;
    logic [10:0] addrb;
    logic [63:0] dinb;
    logic [63:0] doutb = 64'h0;
    logic [5:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] FILLW = 64'h2020202020202020;

    fstore_tty_ctrl dut (
        .clk_data   (clk_data),
        .irst       (irst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .host_en    (host_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .host_dout  (host_dout),
        .enb        (enb),
        .web        (web),
        .addrb      (addrb),
        .dinb       (dinb),
        .doutb      (doutb),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .busy       (busy)
    );

    always #5 clk_data = ~clk_data;

    // Character store model: byte-write, read-first, one-cycle read latency.
    logic [63:0] mem [0:2047];
    always @(posedge clk_data) begin
        if (enb) begin
            doutb <= mem[addrb];
            for (int b = 0; b < 8; b++) begin
                if (web[b]) mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
            end
        end
    end

    // Port-B access log, sampled mid-cycle.
    logic [10:0] log_addr [0:1023];
    logic [7:0]  log_we   [0:1023];
    logic [63:0] log_din  [0:1023];
    int wr_n = 0;
    always @(negedge clk_data) begin
        #2;
        if (enb === 1'b1 && wr_n < 1024) begin
            log_addr[wr_n] = addrb;
            log_we[wr_n]   = web;
            log_din[wr_n]  = dinb;
            wr_n++;
        end
    end

    task automatic send_char(input logic [7:0] c, input int max_cycles);
        int n;
        int m;
        @(negedge clk_data);
        char_valid = 1'b1;
        char_data  = c;
        #1;
        n = 0;
        while (char_ready !== 1'b1 && n < 50) begin
            @(negedge clk_data); #1; n++;
        end
        @(negedge clk_data);
        char_valid = 1'b0;
        #1;
        m = 0;
        while (busy !== 1'b0 && m < max_cycles) begin
            @(negedge clk_data); #1; m++;
        end
        checks++;
        if (n >= 50 || m >= max_cycles) begin
            failures++;
            $display("FAIL send_char_timeout char=%02h ready_wait=%0d busy_wait=%0d limit=%0d", c, n, m, max_cycles);
        end
    endtask

    task automatic test_reset();
        int n;
        int bad;
        repeat (3) @(negedge clk_data);
        #1;
        checks++; if (enb !== 1'b0) begin failures++; $display("FAIL reset_enb got=%b exp=0", enb); end
        checks++; if (web !== 8'h00) begin failures++; $display("FAIL reset_web got=%h exp=00", web); end
        checks++; if (addrb !== 11'h000) begin failures++; $display("FAIL reset_addrb got=%h exp=000", addrb); end
        checks++; if (dinb !== 64'h0) begin failures++; $display("FAIL reset_dinb got=%h exp=0", dinb); end
        checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", char_ready); end
        checks++; if (cur_row !== 6'd0 || cur_col !== 7'd0) begin failures++; $display("FAIL reset_cursor got=%0d,%0d exp=0,0", cur_row, cur_col); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        @(negedge clk_data);
        irst = 1'b0;
        #1;
        wr_n = 0;
        n = 0;
        while (busy === 1'b1 && n < 700) begin
            @(negedge clk_data); #1; n++;
        end
        checks++; if (n !== 512) begin failures++; $display("FAIL cls_busy_cycles got=%0d exp=512", n); end
        checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL cls_ready_after got=%b exp=1", char_ready); end
        checks++; if (wr_n !== 512) begin failures++; $display("FAIL cls_write_count got=%0d exp=512", wr_n); end
        bad = 0;
        for (int i = 0; i < 512 && i < wr_n; i++) begin
            if (log_addr[i] !== 11'(i) || log_we[i] !== 8'hFF || log_din[i] !== FILLW) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL cls_write_contents bad_words=%0d exp=0", bad); end
    endtask

    task automatic test_place_char();
        send_char(8'h0A, 40);
        send_char(8'h0A, 40);
        for (int i = 0; i < 5; i++) send_char(8'h78, 20);
        checks++; if (cur_row !== 6'd2 || cur_col !== 7'd5) begin failures++; $display("FAIL place_setup got=%0d,%0d exp=2,5", cur_row, cur_col); end
        wr_n = 0;
        send_char(8'h41, 20);
        checks++; if (wr_n !== 1) begin failures++; $display("FAIL place_count got=%0d exp=1", wr_n); end
        checks++; if (log_addr[0] !== 11'h020) begin failures++; $display("FAIL place_addr got=%h exp=020", log_addr[0]); end
        checks++; if (log_we[0] !== 8'h20) begin failures++; $display("FAIL place_web got=%h exp=20", log_we[0]); end
        checks++; if (log_din[0] !== 64'h4141414141414141) begin failures++; $display("FAIL place_dinb got=%h exp=4141414141414141", log_din[0]); end
        checks++; if (cur_row !== 6'd2 || cur_col !== 7'd6) begin failures++; $display("FAIL place_cursor got=%0d,%0d exp=2,6", cur_row, cur_col); end
    endtask

    task automatic test_host_read();
        @(negedge clk_data);
        host_en = 1'b1; host_we = 8'h00; host_addr = 11'h020; host_din = 64'h0;
        #1;
        checks++; if (enb !== 1'b1 || web !== 8'h00 || addrb !== 11'h020) begin failures++; $display("FAIL host_rd_port got=%b/%h/%h exp=1/00/020", enb, web, addrb); end
        checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL host_rd_ready got=%b exp=0", char_ready); end
        @(negedge clk_data);
        host_en = 1'b0;
        #1;
        checks++; if (host_dout !== 64'h2020417878787878) begin failures++; $display("FAIL host_rd_data got=%h exp=2020417878787878", host_dout); end
    endtask

    task automatic test_back_to_back();
        int acc;
        acc = 0;
        @(negedge clk_data);
        char_valid = 1'b1; char_data = 8'h42;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (char_valid && char_ready) acc++;
            @(negedge clk_data);
        end
        char_valid = 1'b0;
        #1;
        checks++; if (acc !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc); end
        @(negedge clk_data); #1;
        checks++; if (cur_col !== 7'd10 || busy !== 1'b0) begin failures++; $display("FAIL b2b_cursor col=%0d busy=%b exp=10/0", cur_col, busy); end
    endtask

    task automatic test_wrap();
        int bad;
        send_char(8'h0D, 20);
        for (int i = 0; i < 29; i++) send_char(8'h0A, 40);
        checks++; if (cur_row !== 6'd31 || cur_col !== 7'd0) begin failures++; $display("FAIL wrap_setup got=%0d,%0d exp=31,0", cur_row, cur_col); end
        for (int i = 0; i < 63; i++) send_char(8'h7A, 20);
        checks++; if (cur_row !== 6'd31 || cur_col !== 7'd63) begin failures++; $display("FAIL wrap_col63 got=%0d,%0d exp=31,63", cur_row, cur_col); end
        wr_n = 0;
        send_char(8'h5A, 40);
        checks++; if (wr_n !== 17) begin failures++; $display("FAIL wrap_count got=%0d exp=17", wr_n); end
        checks++; if (log_addr[0] !== 11'h1F7 || log_we[0] !== 8'h80) begin failures++; $display("FAIL wrap_last_char got=%h/%h exp=1F7/80", log_addr[0], log_we[0]); end
        bad = 0;
        for (int i = 1; i < 17 && i < wr_n; i++) begin
            if (log_addr[i] !== 11'(i - 1) || log_we[i] !== 8'hFF || log_din[i] !== FILLW) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_clr_words bad=%0d exp=0", bad); end
        checks++; if (cur_row !== 6'd0 || cur_col !== 7'd0) begin failures++; $display("FAIL wrap_cursor got=%0d,%0d exp=0,0", cur_row, cur_col); end
    endtask

    task automatic test_host_stall();
        int k;
        int h;
        int bad;
        int n;
        @(negedge clk_data);
        char_valid = 1'b1; char_data = 8'h0A;
        #1;
        checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL stall_ready got=%b exp=1", char_ready); end
        @(negedge clk_data);
        char_valid = 1'b0;
        #1;
        wr_n = 0;
        repeat (5) @(negedge clk_data);
        host_en = 1'b1; host_we = 8'h0F; host_addr = 11'h7AB; host_din = 64'hDEADBEEF01234567;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (enb !== 1'b1 || web !== 8'h0F) begin failures++; $display("FAIL stall_host_ctl cyc=%0d got=%b/%h exp=1/0F", i, enb, web); end
            checks++; if (addrb !== 11'h7AB || dinb !== 64'hDEADBEEF01234567) begin failures++; $display("FAIL stall_host_data cyc=%0d got=%h/%h", i, addrb, dinb); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy cyc=%0d got=%b exp=1", i, busy); end
            @(negedge clk_data);
        end
        host_en = 1'b0;
        #1;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin @(negedge clk_data); #1; n++; end
        k = 0; h = 0; bad = 0;
        for (int i = 0; i < wr_n; i++) begin
            if (log_we[i] === 8'hFF) begin
                if (log_addr[i] !== 11'(16 + k) || log_din[i] !== FILLW) bad++;
                k++;
            end else if (log_we[i] === 8'h0F && log_addr[i] === 11'h7AB) begin
                h++;
            end else begin
                bad++;
            end
        end
        checks++; if (k !== 16 || bad !== 0) begin failures++; $display("FAIL stall_clr_seq words=%0d bad=%0d exp=16/0", k, bad); end
        checks++; if (h !== 3) begin failures++; $display("FAIL stall_host_count got=%0d exp=3", h); end
        checks++; if (cur_row !== 6'd1 || busy !== 1'b0) begin failures++; $display("FAIL stall_end row=%0d busy=%b exp=1/0", cur_row, busy); end
    endtask

    task automatic test_bs_ignore_ff();
        int bad;
        wr_n = 0;
        send_char(8'h08, 20);
        send_char(8'h07, 20);
        checks++; if (wr_n !== 0) begin failures++; $display("FAIL bs_bel_writes got=%0d exp=0", wr_n); end
        checks++; if (cur_row !== 6'd1 || cur_col !== 7'd0) begin failures++; $display("FAIL bs_bel_cursor got=%0d,%0d exp=1,0", cur_row, cur_col); end
        send_char(8'h71, 20);
        send_char(8'h08, 20);
        checks++; if (cur_col !== 7'd0 || wr_n !== 1) begin failures++; $display("FAIL bs_back col=%0d writes=%0d exp=0/1", cur_col, wr_n); end
        send_char(8'h61, 20);
        send_char(8'h62, 20);
        send_char(8'h0D, 20);
        checks++; if (cur_col !== 7'd0 || cur_row !== 6'd1) begin failures++; $display("FAIL cr_cursor got=%0d,%0d exp=1,0", cur_row, cur_col); end
        wr_n = 0;
        send_char(8'h0C, 600);
        checks++; if (wr_n !== 512) begin failures++; $display("FAIL ff_count got=%0d exp=512", wr_n); end
        bad = 0;
        for (int i = 0; i < 512 && i < wr_n; i++) begin
            if (log_addr[i] !== 11'(i) || log_we[i] !== 8'hFF || log_din[i] !== FILLW) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL ff_words bad=%0d exp=0", bad); end
        checks++; if (cur_row !== 6'd0 || cur_col !== 7'd0) begin failures++; $display("FAIL ff_cursor got=%0d,%0d exp=0,0", cur_row, cur_col); end
    endtask

    task automatic test_reset_mid_cls();
        int n;
        int bad;
        send_char(8'h33, 20);
        @(negedge clk_data);
        char_valid = 1'b1; char_data = 8'h0C;
        #1;
        @(negedge clk_data);
        char_valid = 1'b0;
        #1;
        n = 0;
        while (!(enb === 1'b1 && addrb === 11'd200) && n < 600) begin @(negedge clk_data); #1; n++; end
        checks++; if (n >= 600) begin failures++; $display("FAIL midcls_reach200 waited=%0d limit=600", n); end
        irst = 1'b1;
        #1;
        checks++; if (enb !== 1'b0 || addrb !== 11'h000 || char_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL midcls_reset_out enb=%b addr=%h rdy=%b busy=%b exp=0/000/0/1", enb, addrb, char_ready, busy); end
        checks++; if (cur_col !== 7'd0 || cur_row !== 6'd0) begin failures++; $display("FAIL midcls_reset_cursor got=%0d,%0d exp=0,0", cur_row, cur_col); end
        @(negedge clk_data);
        irst = 1'b0;
        #1;
        wr_n = 0;
        n = 0;
        while (busy === 1'b1 && n < 700) begin @(negedge clk_data); #1; n++; end
        checks++; if (n !== 512 || wr_n !== 512) begin failures++; $display("FAIL midcls_restart cycles=%0d writes=%0d exp=512/512", n, wr_n); end
        bad = 0;
        for (int i = 0; i < 512 && i < wr_n; i++) begin
            if (log_addr[i] !== 11'(i) || log_we[i] !== 8'hFF || log_din[i] !== FILLW) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL midcls_words bad=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_place_char();
        test_host_read();
        test_back_to_back();
        test_wrap();
        test_host_stall();
        test_bs_ignore_ff();
        test_reset_mid_cls();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
